// File: rtl/sfifo_ctrl.sv
// Synchronous FIFO controller for an external RAM with one-cycle registered read data.
// Pointers, occupancy count and sticky error flags live here; storage lives in the RAM.
module sfifo_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf,
    output logic                  ram_we,
    output logic [7:0]            ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [7:0]            ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_THR = AF_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  pop_valid_q;
    logic                  ovf_q, udf_q;
    logic                  push_ok, pop_ok;

    // Flags come from the registered count, so acceptance never depends on same-cycle ops.
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH);
    assign almost_full = (count_q >= AF_THR);
    assign count       = count_q;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign ram_we    = push_ok;
    assign ram_waddr = 8'(wptr_q);
    assign ram_wdata = push_data;
    assign ram_re    = pop_ok;
    assign ram_raddr = 8'(rptr_q);

    assign pop_data  = ram_rdata;
    assign pop_valid = pop_valid_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

    always_comb begin
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_ok;
            ovf_q       <= ovf_q | (push && full);
            udf_q       <= udf_q | (pop && empty);
        end
    end
endmodule

// File: tb/tb_sfifo_ctrl.sv
// Bench for sfifo_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sfifo_ctrl;
    localparam int DW = 4, AW = 3, DEPTH = 8, AFL = 6;

    logic          clk = 0, rst = 1, push = 0, pop = 0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] pop_data, ram_wdata, ram_rdata;
    logic          pop_valid, full, empty, almost_full, ovf, udf, ram_we, ram_re;
    logic [AW:0]   count;
    logic [7:0]    ram_waddr, ram_raddr;
    logic [DW-1:0] mem [DEPTH];

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sfifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .ovf(ovf), .udf(udf),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    // External RAM with registered read port
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr[AW-1:0]] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr[AW-1:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words plus running push/pop totals.
    int mq[$];
    int m_wr = 0, m_rd = 0, m_pd = 0, sz;
    bit m_ovf = 0, m_udf = 0, m_pv = 0, chk_en = 0;

    always @(posedge clk) begin
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_pv = 0;
        end else begin
            m_pv = pop && sz > 0;
            if (push && sz == DEPTH) m_ovf = 1;
            if (pop && sz == 0) m_udf = 1;
            if (m_pv) begin m_pd = mq.pop_front(); m_rd++; end
            if (push && sz < DEPTH) begin mq.push_back(int'(push_data)); m_wr++; end
        end
        chk_en = 1;
    end

    always @(negedge clk) if (chk_en) begin
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("almost_full", almost_full, mq.size() >= AFL);
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        chk("pop_valid", pop_valid, m_pv);
        if (m_pv) chk("pop_data", pop_data, m_pd);
        chk("ram_we", ram_we, push && mq.size() < DEPTH);
        chk("ram_re", ram_re, pop && mq.size() > 0);
        if (ram_we) begin
            chk("ram_waddr", ram_waddr, m_wr % DEPTH);
            chk("ram_wdata", ram_wdata, push_data);
        end
        if (ram_re) chk("ram_raddr", ram_raddr, m_rd % DEPTH);
    end

    // Comb RAM-port values captured just before the edge of each directed cycle
    logic       l_we, l_re;
    logic [7:0] l_wa;

    task automatic cyc(input bit p, input logic [DW-1:0] d, input bit q, input bit r);
        push = p; push_data = d; pop = q; rst = r;
        #2;
        l_we = ram_we; l_re = ram_re; l_wa = ram_waddr;
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] dv(input int i);
        return DW'((i * 7 + 3) % 16);
    endfunction

    initial begin
        @(posedge clk); #1;
        cyc(0, 0, 0, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_pv", pop_valid, 0);

        // three pushes, then three pops
        cyc(1, 4'h1, 0, 0); chk("wa0", l_wa, 0);
        cyc(1, 4'h2, 0, 0); chk("wa1", l_wa, 1);
        cyc(1, 4'h3, 0, 0); chk("wa2", l_wa, 2);
        chk("pv_before_pop", pop_valid, 0);
        cyc(0, 0, 1, 0); chk("pv1", pop_valid, 1); chk("pd1", pop_data, 4'h1);
        cyc(0, 0, 1, 0); chk("pv2", pop_valid, 1); chk("pd2", pop_data, 4'h2);
        cyc(0, 0, 1, 0); chk("pv3", pop_valid, 1); chk("pd3", pop_data, 4'h3);
        cyc(0, 0, 0, 0); chk("pv_end", pop_valid, 0); chk("empty_end", empty, 1);

        // fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            cyc(1, DW'(i), 0, 0);
            if (i == 4) chk("af_at5", almost_full, 0);
            if (i == 5) chk("af_at6", almost_full, 1);
            if (i == 6) chk("full_at7", full, 0);
            if (i == 7) begin chk("full_at8", full, 1); chk("count8", count, 8); end
        end
        cyc(1, 4'h9, 0, 0);
        chk("ovf_we", l_we, 0); chk("ovf_set", ovf, 1); chk("ovf_count", count, 8);

        // push+pop when full: only the pop goes through
        cyc(1, 4'h5, 1, 0);
        chk("pf_re", l_re, 1); chk("pf_we", l_we, 0);
        chk("pf_count", count, 7); chk("pf_pd", pop_data, 4'h0);
        repeat (7) cyc(0, 0, 1, 0);
        chk("drain_pd", pop_data, 4'h7); chk("drain_empty", empty, 1);

        // push+pop when empty: only the push goes through
        cyc(1, 4'hA, 1, 0);
        chk("pe_we", l_we, 1); chk("pe_re", l_re, 0); chk("pe_count", count, 1);
        chk("pe_pv", pop_valid, 0);
        cyc(0, 0, 1, 0); chk("pe_pd", pop_data, 4'hA);

        // underflow right after reset
        cyc(0, 0, 0, 1);
        chk("r2_ovf", ovf, 0); chk("r2_udf", udf, 0);
        cyc(0, 0, 1, 0);
        chk("udf_set", udf, 1); chk("udf_re", l_re, 0);
        chk("udf_pv", pop_valid, 0); chk("udf_count", count, 0);
        cyc(0, 0, 0, 0); chk("udf_pv2", pop_valid, 0);

        // streaming with pops one cycle behind pushes; pointers wrap twice
        cyc(0, 0, 0, 1);
        for (int i = 0; i <= 20; i++) begin
            cyc(i < 20, dv(i), i > 0, 0);
            if (i < 20) chk("str_wa", l_wa, i % 8);
            if (i > 0) begin
                chk("str_pv", pop_valid, 1);
                chk("str_pd", pop_data, dv(i - 1));
            end
            chk("str_cnt_le1", count <= 1, 1);
        end

        // reset mid-stream with a pop in the reset cycle
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, DW'(i + 1), 0, 0);
        chk("pre_rst_count", count, 5); chk("pre_rst_udf", udf, 1);
        cyc(0, 0, 1, 1);
        chk("mr_count", count, 0); chk("mr_empty", empty, 1);
        chk("mr_pv", pop_valid, 0); chk("mr_ovf", ovf, 0); chk("mr_udf", udf, 0);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sfifo_ctrl.md
SFIFO_CTRL -- requirements
Module: sfifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of a stored word; shall match the RAM data width.
REQ-002 Parameter ADDR_WIDTH, default 3: log2 of FIFO depth (depth 8); shall match the number of used RAM locations.
REQ-003 Parameter AF_LEVEL, default 6: occupancy at or above which almost_full asserts.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 push  input  1  request to enqueue push_data this cycle.
REQ-008 push_data  input  DATA_WIDTH  word to enqueue.
REQ-009 pop  input  1  request to dequeue the head word this cycle.
REQ-010 pop_data  output  DATA_WIDTH  dequeued word; valid when pop_valid=1.
REQ-011 pop_valid  output  1  pop_data carries the word of the pop accepted in the previous cycle.
REQ-012 full, empty, almost_full  output  1 each  occupancy flags.
REQ-013 count  output  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
REQ-014 ovf, udf  output  1 each  sticky overflow and underflow error flags.
REQ-015 ram_we  output  1, ram_waddr  output  8, ram_wdata  output  DATA_WIDTH  drive the RAM write port.
REQ-016 ram_re  output  1, ram_raddr  output  8  drive the RAM read port; ram_rdata  input  DATA_WIDTH  RAM registered read data.

Function
REQ-017 Push accepted iff push=1 and full=0; pop accepted iff pop=1 and empty=0.
REQ-018 Accepted push: ram_we=1, ram_waddr={zeros, wptr}, ram_wdata=push_data in the same cycle (combinational); wptr increments on the next edge.
REQ-019 Accepted pop: ram_re=1, ram_raddr={zeros, rptr} in the same cycle (combinational); rptr increments on the next edge.
REQ-020 ram_we=0 and ram_re=0 in any cycle where the respective operation is not accepted.
REQ-021 wptr and rptr are ADDR_WIDTH bits and wrap from 2^ADDR_WIDTH-1 to 0 without a gap.
REQ-022 pop_valid is a register equal to the previous cycle's pop-accepted; pop_data=ram_rdata (fixed one-cycle read latency).
REQ-023 count: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted.
REQ-024 empty=(count==0), full=(count==2^ADDR_WIDTH), almost_full=(count>=AF_LEVEL); all derived from registered count.
REQ-025 Simultaneous push and pop when empty: push accepted, pop ignored, count becomes 1.
REQ-026 Simultaneous push and pop when full: pop accepted, push ignored, count becomes 2^ADDR_WIDTH-1.
REQ-027 Simultaneous accepted push and pop at 0<count<full: both complete, count unchanged; wptr never equals rptr, so no same-address conflict occurs.
REQ-028 ovf sets on the edge after push=1 with full=1; udf sets on the edge after pop=1 with empty=1; both hold until rst.
REQ-029 A rejected push or pop changes no pointer, count, or RAM contents.

Reset
REQ-030 On a clk edge with rst=1: wptr=0, rptr=0, count=0, pop_valid=0, ovf=0, udf=0; thus empty=1, full=0, almost_full=0.
REQ-031 rst overrides push and pop in the same cycle: no increment is recorded; the RAM port outputs remain as REQ-018/019 compute combinationally, but the stored FIFO state is discarded.
REQ-032 Reset mid-stream: pop_valid is 0 on the cycle after reset even if a pop was accepted in the reset cycle.

Verification
REQ-033 Reset, then push 0x1,0x2,0x3 on consecutive cycles, then pop 3 cycles -> ram_waddr 0,1,2; pop_valid high 3 cycles starting one cycle after the first pop; pop_data 0x1,0x2,0x3; empty=1 at the end.
REQ-034 Push 8 words 0x0..0x7 -> almost_full=1 when count=6, full=1 when count=8; a 9th push sets ovf=1 with count=8 and no ram_we.
REQ-035 Pop when empty after reset -> udf=1, ram_re=0, pop_valid stays 0, count=0.
REQ-036 Push and pop together when full -> count=7, only ram_re asserted; push and pop together when empty -> count=1, only ram_we asserted.
REQ-037 Run 20 pushes and 20 pops with pops interleaved one cycle behind pushes -> pointers wrap through 7->0 twice, output order matches input order, count stays 0..1.
REQ-038 Assert rst for one cycle while count=5 and pop=1 -> next cycle count=0, empty=1, pop_valid=0, ovf=0, udf=0.
